sram_arbiter: RTL

Two-port arbiter and sequencer for the board's external 512K×16 asynchronous SRAM. It sits between the top-level chip module and internal requesters, for example a pattern generator and a frame reader. It serialises their single-word read and write requests onto the shared ADR/DAT/RAMCS/RAMOE/RAMWE lines with glitch-free registered strobes and a configurable access width. The chip module owns the DAT tristate buffer, built from `sram_dat_o`, `sram_dat_oe` and `sram_dat_i`.

---
 rtl/sram_arbiter_if.sv | 34 +++
 rtl/sram_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for sram_arbiter: two single-word
// read/write request channels (req0_*, req1_*).
// master: requester side, slave: arbiter side.
interface sram_arbiter_if;
  logic        req0_valid;
  logic        req0_we;
  logic [18:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        req0_ready;
  logic [15:0] req0_rdata;
  logic        req0_rvalid;

  logic        req1_valid;
  logic        req1_we;
  logic [18:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        req1_ready;
  logic [15:0] req1_rdata;
  logic        req1_rvalid;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_rdata, req0_rvalid,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_rdata, req1_rvalid
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_rdata, req0_rvalid,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_rdata, req1_rvalid
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter/sequencer for a 512Kx16 async SRAM.
// Access sequence IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> IDLE with
// registered strobes. Define SRAM_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise requester 0 has fixed priority.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave req,
  output logic          busy,
  output logic [18:0]   sram_adr,
  output logic [15:0]   sram_dat_o,
  output logic          sram_dat_oe,
  input  logic [15:0]   sram_dat_i,
  output logic          sram_cs_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        owner;
  logic        cur_we;

  logic        idle_ok;
  logic        gnt0;
  logic        gnt1;
  logic        xfer;
  logic        sel_we;
  logic [18:0] sel_addr;
  logic [15:0] sel_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic        last_gnt;

  // Remember which requester won the most recent transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (xfer) begin
      last_gnt <= gnt1;
    end
  end
`endif

  // Grant selection and combinational ready, only in IDLE and out of reset.
  always_comb begin
    idle_ok = (state == IDLE) && rst_n;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    gnt0 = req.req0_valid && (!req.req1_valid || last_gnt);
`else
    gnt0 = req.req0_valid;
`endif
    gnt1           = req.req1_valid && !gnt0;
    req.req0_ready = idle_ok && gnt0;
    req.req1_ready = idle_ok && gnt1;
    xfer           = idle_ok && (gnt0 || gnt1);
    sel_we         = gnt1 ? req.req1_we    : req.req0_we;
    sel_addr       = gnt1 ? req.req1_addr  : req.req0_addr;
    sel_wdata      = gnt1 ? req.req1_wdata : req.req0_wdata;
  end

  always_comb busy = (state != IDLE);

  // Access sequencer with registered SRAM strobes and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      owner           <= 1'b0;
      cur_we          <= 1'b0;
      sram_adr        <= '0;
      sram_dat_o      <= '0;
      sram_dat_oe     <= 1'b0;
      sram_cs_n       <= 1'b1;
      sram_oe_n       <= 1'b1;
      sram_we_n       <= 1'b1;
      req.req0_rdata  <= '0;
      req.req0_rvalid <= 1'b0;
      req.req1_rdata  <= '0;
      req.req1_rvalid <= 1'b0;
    end else begin
      req.req0_rvalid <= 1'b0;
      req.req1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            state       <= SETUP;
            owner       <= gnt1;
            cur_we      <= sel_we;
            cnt         <= WAIT_INIT;
            sram_adr    <= sel_addr;
            sram_cs_n   <= 1'b0;
            sram_dat_oe <= sel_we;
            if (sel_we) begin
              sram_dat_o <= sel_wdata;
            end
          end
        end
        SETUP: begin
          state <= ACCESS;
          if (cur_we) begin
            sram_we_n <= 1'b0;
          end else begin
            sram_oe_n <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt <= 4'd1) begin
            state     <= HOLD;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!cur_we) begin
              if (owner) begin
                req.req1_rdata  <= sram_dat_i;
                req.req1_rvalid <= 1'b1;
              end else begin
                req.req0_rdata  <= sram_dat_i;
                req.req0_rvalid <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state       <= IDLE;
          sram_cs_n   <= 1'b1;
          sram_dat_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
